// File: rtl/csr_timer.sv
// rtl/csr_timer.sv - constant timer (TID/TCFG/TVAL/TICLR) and 64-bit stable counter
module csr_timer #(
  parameter logic [31:0] CORE_ID = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        csr_re,
  input  logic [13:0] csr_num,
  input  logic        csr_we,
  input  logic [31:0] csr_wmask,
  input  logic [31:0] csr_wvalue,
  output logic        timer_hit,
  output logic [31:0] timer_rvalue,
  output logic        timer_int,
  output logic [63:0] stable_cnt,
  output logic [31:0] counter_id
);

  localparam logic [13:0] NUM_TID   = 14'h40;
  localparam logic [13:0] NUM_TCFG  = 14'h41;
  localparam logic [13:0] NUM_TVAL  = 14'h42;
  localparam logic [13:0] NUM_TICLR = 14'h44;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COUNT,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] tid_q, tid_d;
  logic [31:0] tcfg_q, tcfg_d;
  logic [31:0] tval_q, tval_d;
  logic        int_q, int_d;
  logic [63:0] cnt_q, cnt_d;

  logic        sel_tid, sel_tcfg, sel_tval, sel_ticlr;
  logic        wr_tid, wr_tcfg, ticlr_clr;
  logic        expire;

  // Address decode and write strobes for the owned CSR numbers
  always_comb begin
    sel_tid   = (csr_num == NUM_TID);
    sel_tcfg  = (csr_num == NUM_TCFG);
    sel_tval  = (csr_num == NUM_TVAL);
    sel_ticlr = (csr_num == NUM_TICLR);
    wr_tid    = csr_we & sel_tid;
    wr_tcfg   = csr_we & sel_tcfg;
    ticlr_clr = csr_we & sel_ticlr & csr_wmask[0] & csr_wvalue[0];
    timer_hit = (csr_re | csr_we) & (sel_tid | sel_tcfg | sel_tval | sel_ticlr);
  end

  // Read mux: no bypass, so a same-cycle write still reads the old value
  always_comb begin
    timer_rvalue = 32'h0;
    if (sel_tid) begin
      timer_rvalue = tid_q;
    end else if (sel_tcfg) begin
      timer_rvalue = tcfg_q;
    end else if (sel_tval) begin
      timer_rvalue = tval_q;
    end
  end

  // Next-state: TCFG writes override the countdown; expiry beats a same-cycle TICLR clear
  always_comb begin
    state_d = state_q;
    tid_d   = tid_q;
    tcfg_d  = tcfg_q;
    tval_d  = tval_q;
    int_d   = int_q;
    cnt_d   = cnt_q + 64'd1;
    expire  = 1'b0;

    if (wr_tid) begin
      tid_d = (csr_wmask & csr_wvalue) | (~csr_wmask & tid_q);
    end

    if (wr_tcfg) begin
      tcfg_d = (csr_wmask & csr_wvalue) | (~csr_wmask & tcfg_q);
      if (tcfg_d[0]) begin
        tval_d  = {tcfg_d[31:2], 2'b00};
        state_d = S_COUNT;
      end else begin
        state_d = S_IDLE;
      end
    end else begin
      case (state_q)
        S_COUNT: begin
          if (tval_q != 32'h0) begin
            tval_d = tval_q - 32'd1;
          end else begin
            expire = 1'b1;
            if (tcfg_q[1]) begin
              tval_d = {tcfg_q[31:2], 2'b00};
            end else begin
              tval_d  = 32'hFFFF_FFFF;
              state_d = S_DONE;
            end
          end
        end
        default: ;
      endcase
    end

    if (expire) begin
      int_d = 1'b1;
    end else if (ticlr_clr) begin
      int_d = 1'b0;
    end
  end

  // State and register storage with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      tid_q   <= CORE_ID;
      tcfg_q  <= 32'h0;
      tval_q  <= 32'h0;
      int_q   <= 1'b0;
      cnt_q   <= 64'h0;
    end else begin
      state_q <= state_d;
      tid_q   <= tid_d;
      tcfg_q  <= tcfg_d;
      tval_q  <= tval_d;
      int_q   <= int_d;
      cnt_q   <= cnt_d;
    end
  end

  assign timer_int  = int_q;
  assign stable_cnt = cnt_q;
  assign counter_id = tid_q;

endmodule
